regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/fdt16_pkg.sv | 24 ++
 rtl/regfile_write_arbiter_if.sv | 43 ++++
 rtl/regfile_write_arbiter_rr.sv | 42 ++++
 rtl/regfile_write_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/fdt16_pkg.sv
// Shared definitions for the register-file writeback path: data width,
// source identifiers, register identifiers and a contention helper.
package fdt16_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    localparam logic REG_R0 = 1'b0;
    localparam logic REG_R1 = 1'b1;

    // True when both writeback sources want the same register this cycle.
    function automatic logic same_reg_contention(
        input logic alu_valid,
        input logic mem_valid,
        input logic alu_reg_id,
        input logic mem_reg_id
    );
        return alu_valid & mem_valid & (alu_reg_id == mem_reg_id);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback request ports, the register-file write port
// and the contention counter seen by the write arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = fdt16_pkg::DATA_W,
    parameter int CNT_W  = fdt16_pkg::CNT_W
);

    logic              alu_valid;
    logic              alu_reg_id;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic              mem_reg_id;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              wr_stall;
    logic              wr_enable;
    logic              wr_reg_id;
    logic [DATA_W-1:0] wr_data;
    logic              wr_src;
    logic [CNT_W-1:0]  collision_cnt;

    // Requesters and register-file side.
    modport master (
        output alu_valid, alu_reg_id, alu_data,
        output mem_valid, mem_reg_id, mem_data,
        output wr_stall,
        input  alu_ready, mem_ready,
        input  wr_enable, wr_reg_id, wr_data, wr_src, collision_cnt
    );

    // The arbiter itself.
    modport slave (
        input  alu_valid, alu_reg_id, alu_data,
        input  mem_valid, mem_reg_id, mem_data,
        input  wr_stall,
        output alu_ready, mem_ready,
        output wr_enable, wr_reg_id, wr_data, wr_src, collision_cnt
    );

endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// Two-way round-robin grant logic; the priority pointer lives here and
// flips to the losing side after every accepted transfer.
module rr_arbiter2
    import fdt16_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       stall,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic       prio_r;
    logic [1:0] gnt_s;

    // Grant selection: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        gnt_s = 2'b00;
        if (stall) begin
            gnt_s = 2'b00;
        end else if (req == 2'b11) begin
            gnt_s = (prio_r == SRC_MEM) ? 2'b10 : 2'b01;
        end else begin
            gnt_s = req;
        end
    end

    assign gnt = gnt_s;

    // Priority pointer update after each transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_r <= SRC_ALU;
        end else if (advance) begin
            prio_r <= gnt_s[SRC_ALU] ? SRC_MEM : SRC_ALU;
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto the single register-file
// write port, one write per cycle, and counts same-register contention.
module regfile_write_arbiter
    import fdt16_pkg::*;
#(
    parameter int DATA_W = fdt16_pkg::DATA_W,
    parameter int CNT_W  = fdt16_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              arb_stall_s;
    logic              xfer_s;
    logic              contention_s;

    logic              win_src_s;
    logic              win_reg_s;
    logic [DATA_W-1:0] win_data_s;

    logic              wr_enable_r;
    logic              wr_reg_id_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              wr_src_r;
    logic [CNT_W-1:0]  collision_cnt_r;

    assign req_s       = {bus.mem_valid, bus.alu_valid};
    // Holding grants off during reset keeps both ready outputs low.
    assign arb_stall_s = bus.wr_stall | reset;
    assign xfer_s      = |gnt_s;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_s),
        .stall   (arb_stall_s),
        .advance (xfer_s),
        .gnt     (gnt_s)
    );

    // Winner selection for the registered write port.
    always_comb begin
        win_src_s  = SRC_ALU;
        win_reg_s  = bus.alu_reg_id;
        win_data_s = bus.alu_data;
        if (gnt_s[SRC_MEM]) begin
            win_src_s  = SRC_MEM;
            win_reg_s  = bus.mem_reg_id;
            win_data_s = bus.mem_data;
        end else begin
            win_src_s  = SRC_ALU;
            win_reg_s  = bus.alu_reg_id;
            win_data_s = bus.alu_data;
        end
    end

    assign contention_s = same_reg_contention(bus.alu_valid, bus.mem_valid,
                                              bus.alu_reg_id, bus.mem_reg_id);

    // Write port register: strobe for one cycle per transfer, hold payload otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_enable_r <= 1'b0;
            wr_reg_id_r <= REG_R0;
            wr_data_r   <= {DATA_W{1'b0}};
            wr_src_r    <= SRC_ALU;
        end else if (xfer_s) begin
            wr_enable_r <= 1'b1;
            wr_reg_id_r <= win_reg_s;
            wr_data_r   <= win_data_s;
            wr_src_r    <= win_src_s;
        end else begin
            wr_enable_r <= 1'b0;
            wr_reg_id_r <= wr_reg_id_r;
            wr_data_r   <= wr_data_r;
            wr_src_r    <= wr_src_r;
        end
    end

    // Saturating contention counter; counts even while the register file stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            collision_cnt_r <= {CNT_W{1'b0}};
        end else if (contention_s && (collision_cnt_r != {CNT_W{1'b1}})) begin
            collision_cnt_r <= collision_cnt_r + CNT_W'(1);
        end else begin
            collision_cnt_r <= collision_cnt_r;
        end
    end

    assign bus.alu_ready     = gnt_s[SRC_ALU];
    assign bus.mem_ready     = gnt_s[SRC_MEM];
    assign bus.wr_enable     = wr_enable_r;
    assign bus.wr_reg_id     = wr_reg_id_r;
    assign bus.wr_data       = wr_data_r;
    assign bus.wr_src        = wr_src_r;
    assign bus.collision_cnt = collision_cnt_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, contention
// saturation run, and randomized traffic against a reference model.
module tb_regfile_write_arbiter;

    localparam int DW = 16;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    regfile_write_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state: arbitration turn, expected write port, counter.
    int              m_turn_mem;
    logic            m_en;
    logic            m_reg;
    logic [DW-1:0]   m_data;
    logic            m_src;
    int              m_cnt;
    int              wait_a;
    int              wait_m;

    typedef struct {
        logic          rs, av, ar;
        logic [DW-1:0] ad;
        logic          mv, mr;
        logic [DW-1:0] md;
        logic          st;
        logic          e_ar, e_mr, e_en, e_reg;
        logic [DW-1:0] e_data;
        logic          e_src;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(
        input logic rs, input logic av, input logic ar, input logic [DW-1:0] ad,
        input logic mv, input logic mr, input logic [DW-1:0] md, input logic st,
        input logic e_ar, input logic e_mr, input logic e_en, input logic e_reg,
        input logic [DW-1:0] e_data, input logic e_src, input logic [CW-1:0] e_cnt);
        vec_t v;
        v.rs = rs; v.av = av; v.ar = ar; v.ad = ad;
        v.mv = mv; v.mr = mr; v.md = md; v.st = st;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_en = e_en; v.e_reg = e_reg;
        v.e_data = e_data; v.e_src = e_src; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, check readies against the model, clock,
    // update the model and check the registered outputs.
    task automatic cycle(
        input logic rs, input logic av, input logic ar, input logic [DW-1:0] ad,
        input logic mv, input logic mr, input logic [DW-1:0] md, input logic st,
        output logic o_ar, output logic o_mr, output logic o_en, output logic o_reg,
        output logic [DW-1:0] o_data, output logic o_src, output logic [CW-1:0] o_cnt);
        bit ga, gm;
        reset          = rs;
        bus.alu_valid  = av;
        bus.alu_reg_id = ar;
        bus.alu_data   = ad;
        bus.mem_valid  = mv;
        bus.mem_reg_id = mr;
        bus.mem_data   = md;
        bus.wr_stall   = st;
        #1;
        ga = 1'b0;
        gm = 1'b0;
        if (!rs && !st) begin
            if (av && mv) begin
                if (m_turn_mem != 0) gm = 1'b1; else ga = 1'b1;
            end else begin
                ga = av;
                gm = mv;
            end
        end
        o_ar = bus.alu_ready;
        o_mr = bus.mem_ready;
        chk("model_alu_ready", 32'(o_ar), 32'(ga));
        chk("model_mem_ready", 32'(o_mr), 32'(gm));
        // Starvation: a valid port must not miss two non-stalled cycles in a row.
        if (rs) begin
            wait_a = 0;
            wait_m = 0;
        end else if (!st) begin
            if (av && !o_ar) wait_a++; else wait_a = 0;
            if (mv && !o_mr) wait_m++; else wait_m = 0;
            if (av) chk("starve_alu", 32'(wait_a < 2), 32'd1);
            if (mv) chk("starve_mem", 32'(wait_m < 2), 32'd1);
        end
        @(posedge clk);
        #1;
        if (rs) begin
            m_en = 1'b0; m_reg = 1'b0; m_data = '0; m_src = 1'b0;
            m_turn_mem = 0; m_cnt = 0;
        end else begin
            if (av && mv && (ar == mr) && m_cnt < 255) m_cnt++;
            m_en = ga | gm;
            if (ga) begin
                m_reg = ar; m_data = ad; m_src = 1'b0; m_turn_mem = 1;
            end
            if (gm) begin
                m_reg = mr; m_data = md; m_src = 1'b1; m_turn_mem = 0;
            end
        end
        o_en   = bus.wr_enable;
        o_reg  = bus.wr_reg_id;
        o_data = bus.wr_data;
        o_src  = bus.wr_src;
        o_cnt  = bus.collision_cnt;
        chk("model_wr_enable", 32'(o_en), 32'(m_en));
        chk("model_wr_reg_id", 32'(o_reg), 32'(m_reg));
        chk("model_wr_data", 32'(o_data), 32'(m_data));
        chk("model_wr_src", 32'(o_src), 32'(m_src));
        chk("model_collision_cnt", 32'(o_cnt), 32'(m_cnt));
        @(negedge clk);
    endtask

    logic            s_ar, s_mr, s_en, s_reg, s_src;
    logic [DW-1:0]   s_data;
    logic [CW-1:0]   s_cnt;
    logic            pa, pm, par, pmr, rs_r, st_r;
    logic [DW-1:0]   pad, pmd;

    initial begin
        bus.alu_valid = 1'b0; bus.alu_reg_id = 1'b0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_reg_id = 1'b0; bus.mem_data = '0;
        bus.wr_stall  = 1'b0;
        m_turn_mem = 0; m_en = 1'b0; m_reg = 1'b0; m_data = '0; m_src = 1'b0; m_cnt = 0;
        wait_a = 0; wait_m = 0;

        //               rs    av    ar    ad         mv    mr    md         st    e_ar  e_mr  e_en  e_reg e_data     e_src e_cnt
        vq.push_back(mkv(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0));
        vq.push_back(mkv(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0));
        vq.push_back(mkv(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 8'd0));
        vq.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 8'd0));
        vq.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0F0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0F0F, 1'b1, 8'd0));
        vq.push_back(mkv(1'b0, 1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hAAAA, 1'b0, 8'd0));
        vq.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5555, 1'b1, 8'd0));
        vq.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b1, 8'd0));
        vq.push_back(mkv(1'b0, 1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111, 1'b0, 8'd1));
        vq.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h2222, 1'b1, 8'd1));
        vq.push_back(mkv(1'b0, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, 8'd1));
        vq.push_back(mkv(1'b0, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, 8'd1));
        vq.push_back(mkv(1'b0, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, 8'd1));
        vq.push_back(mkv(1'b0, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3333, 1'b0, 8'd1));
        vq.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4444, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4444, 1'b1, 8'd1));
        vq.push_back(mkv(1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4444, 1'b1, 8'd2));
        vq.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h9999, 1'b1, 8'd2));
        vq.push_back(mkv(1'b1, 1'b1, 1'b1, 16'h7777, 1'b1, 1'b1, 16'h8888, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0));
        vq.push_back(mkv(1'b0, 1'b1, 1'b1, 16'h7777, 1'b1, 1'b0, 16'h8888, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h7777, 1'b0, 8'd0));
        vq.push_back(mkv(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777, 1'b0, 8'd0));

        for (int i = 0; i < vq.size(); i++) begin
            cycle(vq[i].rs, vq[i].av, vq[i].ar, vq[i].ad, vq[i].mv, vq[i].mr, vq[i].md, vq[i].st,
                  s_ar, s_mr, s_en, s_reg, s_data, s_src, s_cnt);
            chk($sformatf("vec%0d_alu_ready", i), 32'(s_ar), 32'(vq[i].e_ar));
            chk($sformatf("vec%0d_mem_ready", i), 32'(s_mr), 32'(vq[i].e_mr));
            chk($sformatf("vec%0d_wr_enable", i), 32'(s_en), 32'(vq[i].e_en));
            chk($sformatf("vec%0d_wr_reg_id", i), 32'(s_reg), 32'(vq[i].e_reg));
            chk($sformatf("vec%0d_wr_data", i), 32'(s_data), 32'(vq[i].e_data));
            chk($sformatf("vec%0d_wr_src", i), 32'(s_src), 32'(vq[i].e_src));
            chk($sformatf("vec%0d_collision_cnt", i), 32'(s_cnt), 32'(vq[i].e_cnt));
        end

        // Long same-register contention held off by a stall: counter saturates.
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'hCAFE, 1'b1,
                  s_ar, s_mr, s_en, s_reg, s_data, s_src, s_cnt);
        end
        chk("sat_cnt_255", 32'(s_cnt), 32'd255);
        chk("sat_wr_data_held", 32'(s_data), 32'h7777);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1, 16'hCAFE, 1'b0,
                  s_ar, s_mr, s_en, s_reg, s_data, s_src, s_cnt);
        end
        chk("sat_cnt_hold", 32'(s_cnt), 32'd255);

        // Randomized traffic; requesters hold their request until accepted.
        pa = 1'b0; pm = 1'b0; par = 1'b0; pmr = 1'b0; pad = '0; pmd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pa && $urandom_range(0, 3) != 0) begin
                pa = 1'b1; par = 1'($urandom_range(0, 1)); pad = 16'($urandom);
            end
            if (!pm && $urandom_range(0, 3) != 0) begin
                pm = 1'b1; pmr = 1'($urandom_range(0, 1)); pmd = 16'($urandom);
            end
            st_r = ($urandom_range(0, 4) == 0);
            rs_r = ($urandom_range(0, 63) == 0);
            cycle(rs_r, pa, par, pad, pm, pmr, pmd, st_r,
                  s_ar, s_mr, s_en, s_reg, s_data, s_src, s_cnt);
            if (s_ar) pa = 1'b0;
            if (s_mr) pm = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
